// File: rtl/gbarpi_spi_pkg.sv
// Shared types and constants for the SPI0 framebuffer link: FSM states,
// the memory-write command byte and the shift-engine widths.
package gbarpi_spi_pkg;

  localparam logic [7:0] SPI_CMD_MEMWRITE = 8'h2C;
  localparam int         WORD_W           = 16;
  localparam int         BIT_CNT_W        = 4;

  localparam logic [BIT_CNT_W-1:0] CMD_LAST_BIT  = 4'd7;
  localparam logic [BIT_CNT_W-1:0] WORD_LAST_BIT = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_CMD      = 3'd2,
    ST_FETCH    = 3'd3,
    ST_DATA     = 3'd4,
    ST_CS_HOLD  = 3'd5,
    ST_GAP      = 3'd6
  } spi_state_e;

endpackage

// File: rtl/spi_shift_engine.sv
// Mode-0 SPI shifter: serialises a left-aligned word MSB first, SCLK low then
// high for CLK_DIV cycles per phase; MOSI only moves on the falling edge.
module spi_shift_engine
  import gbarpi_spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [WORD_W-1:0]    load_data,
  input  logic [BIT_CNT_W-1:0] bit_last,
  output logic                 sclk,
  output logic                 mosi,
  output logic                 bit_done,
  output logic                 word_done
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic                 active;
  logic [DIV_W-1:0]     div_cnt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [WORD_W-1:0]    shreg;
  logic                 div_last;

  assign div_last  = (div_cnt == DIV_LAST);
  // Strobes fire in the last high cycle, so the falling edge and the shift share one clock edge.
  assign bit_done  = active && sclk && div_last;
  assign word_done = bit_done && (bit_cnt == bit_last);
  assign mosi      = shreg[WORD_W-1];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      active  <= 1'b0;
      sclk    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (start) begin
      active  <= 1'b1;
      sclk    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (active) begin
      if (div_last) begin
        div_cnt <= '0;
        sclk    <= ~sclk;
        if (sclk) begin
          if (bit_cnt == bit_last) active <= 1'b0;
          else                     bit_cnt <= bit_cnt + 1'b1;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start)         shreg <= load_data;
    else if (bit_done) shreg <= {shreg[WORD_W-2:0], 1'b0};
  end

endmodule

// File: rtl/spi_frame_transmitter.sv
// SPI0 frame sender: one command byte (DC=0) followed by FRAME_WORDS pixel
// words (DC=1) fetched through a req/valid read port, CSn low for the frame.
module spi_frame_transmitter
  import gbarpi_spi_pkg::*;
#(
  parameter int         CLK_DIV     = 2,
  parameter int         FRAME_WORDS = 38400,
  parameter int         ADDR_W      = 17,
  parameter logic [7:0] CMD_BYTE    = SPI_CMD_MEMWRITE
) (
  input  logic              IwClk,
  input  logic              IwResetn,
  input  logic              IwStart,
  output logic              OwBusy,
  output logic              OwDone,
  output logic [ADDR_W-1:0] ObReadAddr,
  output logic              OwReadReq,
  input  logic [15:0]       IbReadData,
  input  logic              IwReadValid,
  output logic              ObCSn,
  output logic              ObSCLK,
  output logic              ObMOSI,
  output logic              ObDC
);

  localparam int               IDX_W     = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int               TMR_W     = $clog2(2 * CLK_DIV + 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FRAME_WORDS - 1);
  localparam logic [TMR_W-1:0] EDGE_LAST = TMR_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(2 * CLK_DIV - 1);

  spi_state_e           state;
  spi_state_e           state_next;
  logic [TMR_W-1:0]     tmr;
  logic [IDX_W-1:0]     word_idx;
  logic                 done_q;
  logic                 eng_start;
  logic                 eng_sclk;
  logic                 eng_mosi;
  logic                 eng_bit_done;
  logic                 eng_word_done;
  logic                 word_end;
  logic [WORD_W-1:0]    eng_load;
  logic [BIT_CNT_W-1:0] eng_last;

  always_ff @(posedge IwClk) begin
    if (!IwResetn) state <= ST_IDLE;
    else           state <= state_next;
  end

  // Phase timer restarts on every state change; it saturates rather than wraps.
  always_ff @(posedge IwClk) begin
    if (!IwResetn || state_next != state) tmr <= '0;
    else if (tmr != GAP_LAST)             tmr <= tmr + 1'b1;
  end

  always_ff @(posedge IwClk) begin
    if (!IwResetn)                 word_idx <= '0;
    else if (state == ST_IDLE)     word_idx <= '0;
    else if (state == ST_DATA && word_end && word_idx != IDX_LAST)
                                   word_idx <= word_idx + 1'b1;
  end

  always_ff @(posedge IwClk) begin
    if (!IwResetn) done_q <= 1'b0;
    else           done_q <= (state == ST_GAP) && (tmr == GAP_LAST);
  end

  always_comb begin
    state_next = state;
    case (state)
      // done_q blocks a start landing in the Done cycle itself.
      ST_IDLE:     if (IwStart && !done_q)  state_next = ST_CS_SETUP;
      ST_CS_SETUP: if (tmr == EDGE_LAST)    state_next = ST_CMD;
      ST_CMD:      if (word_end)            state_next = ST_FETCH;
      ST_FETCH:    if (IwReadValid)         state_next = ST_DATA;
      ST_DATA:     if (word_end)            state_next = (word_idx == IDX_LAST) ? ST_CS_HOLD : ST_FETCH;
      ST_CS_HOLD:  if (tmr == EDGE_LAST)    state_next = ST_GAP;
      ST_GAP:      if (tmr == GAP_LAST)     state_next = ST_IDLE;
      default:                              state_next = ST_IDLE;
    endcase
  end

  assign word_end  = eng_bit_done && eng_word_done;
  assign eng_start = ((state == ST_CS_SETUP) && (tmr == EDGE_LAST)) ||
                     ((state == ST_FETCH) && IwReadValid);
  assign eng_load  = (state == ST_FETCH) ? IbReadData : {CMD_BYTE, {(WORD_W-8){1'b0}}};
  assign eng_last  = (state == ST_CMD || state == ST_CS_SETUP) ? CMD_LAST_BIT : WORD_LAST_BIT;

  spi_shift_engine #(
    .CLK_DIV (CLK_DIV)
  ) u_shift (
    .clk       (IwClk),
    .resetn    (IwResetn),
    .start     (eng_start),
    .load_data (eng_load),
    .bit_last  (eng_last),
    .sclk      (eng_sclk),
    .mosi      (eng_mosi),
    .bit_done  (eng_bit_done),
    .word_done (eng_word_done)
  );

  always_comb begin
    ObCSn      = (state == ST_IDLE) || (state == ST_GAP);
    ObSCLK     = eng_sclk;
    ObMOSI     = 1'b0;
    ObDC       = 1'b0;
    OwBusy     = (state != ST_IDLE);
    OwDone     = done_q;
    OwReadReq  = (state == ST_FETCH);
    ObReadAddr = ADDR_W'(word_idx);
    case (state)
      ST_CS_SETUP: ObMOSI = CMD_BYTE[7];
      ST_CMD:      ObMOSI = eng_mosi;
      ST_DATA:     begin ObMOSI = eng_mosi; ObDC = 1'b1; end
      ST_FETCH:    ObDC = (word_idx != '0);
      ST_CS_HOLD:  ObDC = 1'b1;
      default:     ObMOSI = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_spi_frame_transmitter.sv
// Directed bench: two transmitters (CLK_DIV=2 and CLK_DIV=1, 4-word frames),
// each with a latency-programmable memory and an SPI receiver model.
module tb_spi_frame_transmitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn0 = 1'b0, rstn1 = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0;
  logic rand_mode = 1'b0;
  logic mon_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic        rstn, start, busy, done, req, valid, csn, sclk, mosi, dc;
    logic [16:0] addr;
    logic [15:0] rdata;
    logic        junk = 1'b0;
    int          cnt = 0;
    int          lat = 1;

    assign rstn  = (g == 0) ? rstn0 : rstn1;
    assign start = (g == 0) ? start0 : start1;

    spi_frame_transmitter #(
      .CLK_DIV     ((g == 0) ? 2 : 1),
      .FRAME_WORDS (4),
      .ADDR_W      (17),
      .CMD_BYTE    (8'h2C)
    ) u_dut (
      .IwClk       (clk),
      .IwResetn    (rstn),
      .IwStart     (start),
      .OwBusy      (busy),
      .OwDone      (done),
      .ObReadAddr  (addr),
      .OwReadReq   (req),
      .IbReadData  (rdata),
      .IwReadValid (valid),
      .ObCSn       (csn),
      .ObSCLK      (sclk),
      .ObMOSI      (mosi),
      .ObDC        (dc)
    );

    // Memory: valid arrives lat cycles after req; junk valids appear while req is low.
    assign valid = (req && (cnt >= lat)) || (!req && junk);
    assign rdata = req ? (16'hA5C3 + addr[15:0]) : 16'hDEAD;

    always @(posedge clk) begin
      if (req && !valid) cnt <= cnt + 1;
      else               cnt <= 0;
      if (!req) lat <= rand_mode ? int'($urandom_range(7, 0)) : 1;
      junk <= rand_mode && ($urandom_range(1, 0) == 1);
    end

    // Receiver model sampling between clock edges.
    int          done_cnt, busy_cyc, fetch_sclk_err, mosi_unstable, cs_mid_rise, sclk_hold_err, nbits;
    logic [15:0] sh;
    logic        prev_sclk = 1'b0, prev_mosi = 1'b0, prev_csn = 1'b1;
    logic [7:0]  cmd_q[$];
    logic [15:0] word_q[$];

    always @(negedge clk) begin
      if (mon_clr) begin
        done_cnt = 0; busy_cyc = 0; fetch_sclk_err = 0; mosi_unstable = 0;
        cs_mid_rise = 0; sclk_hold_err = 0; nbits = 0;
        cmd_q.delete(); word_q.delete();
      end
      if (busy === 1'b1) busy_cyc++;
      if (done === 1'b1) done_cnt++;
      if (req === 1'b1 && sclk === 1'b1) fetch_sclk_err++;
      if (sclk === 1'b1 && prev_sclk === 1'b1) sclk_hold_err++;
      if (csn === 1'b1 && prev_csn === 1'b0 && word_q.size() < 4) cs_mid_rise++;
      if (csn !== 1'b0) begin
        nbits = 0;
      end else if (sclk === 1'b1 && prev_sclk === 1'b0) begin
        if (mosi !== prev_mosi) mosi_unstable++;
        sh = {sh[14:0], mosi};
        nbits++;
        if (dc === 1'b0 && nbits == 8) begin
          cmd_q.push_back(sh[7:0]);
          nbits = 0;
        end else if (dc === 1'b1 && nbits == 16) begin
          word_q.push_back(sh);
          nbits = 0;
        end
      end
      prev_sclk = sclk;
      prev_mosi = mosi;
      prev_csn  = csn;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int which, input int budget);
    int n = 0;
    while (((which == 0) ? g_dut[0].done : g_dut[1].done) !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("done_seen", {31'd0, ((which == 0) ? g_dut[0].done : g_dut[1].done)}, 32'd1);
  endtask

  task automatic wait_data0(input int word, input int budget);
    int n = 0;
    while (!(g_dut[0].dc === 1'b1 && g_dut[0].sclk === 1'b1 && g_dut[0].addr == 17'(word)) && n < budget) begin
      tick();
      n++;
    end
    chk("data_phase_seen", {31'd0, g_dut[0].sclk}, 32'd1);
  endtask

  task automatic chk_frame0(input string tag);
    chk({tag, "_ncmd"}, g_dut[0].cmd_q.size(), 32'd1);
    chk({tag, "_cmd"}, {24'd0, g_dut[0].cmd_q[0]}, 32'h2C);
    chk({tag, "_nwords"}, g_dut[0].word_q.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      chk({tag, "_word"}, {16'd0, g_dut[0].word_q[i]}, 32'hA5C3 + 32'(i));
    chk({tag, "_ndone"}, g_dut[0].done_cnt, 32'd1);
  endtask

  initial begin
    // Reset state
    tick(); tick(); tick();
    chk("rst_csn",  {31'd0, g_dut[0].csn},  32'd1);
    chk("rst_sclk", {31'd0, g_dut[0].sclk}, 32'd0);
    chk("rst_mosi", {31'd0, g_dut[0].mosi}, 32'd0);
    chk("rst_dc",   {31'd0, g_dut[0].dc},   32'd0);
    chk("rst_busy", {31'd0, g_dut[0].busy}, 32'd0);
    chk("rst_done", {31'd0, g_dut[0].done}, 32'd0);
    chk("rst_req",  {31'd0, g_dut[0].req},  32'd0);
    chk("rst_addr", {15'd0, g_dut[0].addr}, 32'd0);
    rstn0 = 1'b1;
    rstn1 = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    chk("idle_csn",  {31'd0, g_dut[0].csn},  32'd1);
    chk("idle_sclk", {31'd0, g_dut[0].sclk}, 32'd0);
    chk("idle_busy", {31'd0, g_dut[0].busy}, 32'd0);
    chk("idle_req",  {31'd0, g_dut[0].req},  32'd0);

    // Frame 1: fixed 1-cycle read latency
    mon_clr = 1'b1; start0 = 1'b1;
    tick();
    mon_clr = 1'b0; start0 = 1'b0;
    chk("f1_busy_next", {31'd0, g_dut[0].busy}, 32'd1);
    chk("f1_csn_low",   {31'd0, g_dut[0].csn},  32'd0);
    chk("f1_dc_cmd",    {31'd0, g_dut[0].dc},   32'd0);
    wait_done(0, 2000);
    chk("f1_busy_at_done", {31'd0, g_dut[0].busy}, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    chk_frame0("f1");
    chk("f1_busy_cycles", g_dut[0].busy_cyc, 32'd304);
    chk("f1_fetch_sclk", g_dut[0].fetch_sclk_err, 32'd0);
    chk("f1_mosi_stable", g_dut[0].mosi_unstable, 32'd0);
    chk("f1_cs_mid_rise", g_dut[0].cs_mid_rise, 32'd0);

    // Frame 2: random latency, start during DATA and in the Done cycle
    rand_mode = 1'b1;
    mon_clr = 1'b1; start0 = 1'b1;
    tick();
    mon_clr = 1'b0; start0 = 1'b0;
    wait_data0(0, 500);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk("f2_busy_after_data_start", {31'd0, g_dut[0].busy}, 32'd1);
    wait_done(0, 3000);
    start0 = 1'b1;
    tick();
    chk("f2_start_in_done_ignored", {31'd0, g_dut[0].busy}, 32'd0);
    chk_frame0("f2");
    chk("f2_fetch_sclk", g_dut[0].fetch_sclk_err, 32'd0);
    chk("f2_cs_mid_rise", g_dut[0].cs_mid_rise, 32'd0);
    chk("f2_mosi_stable", g_dut[0].mosi_unstable, 32'd0);
    rand_mode = 1'b0;
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0; start0 = 1'b0;
    chk("f3_start_after_done", {31'd0, g_dut[0].busy}, 32'd1);

    // Frame 3: reset during word 2
    wait_data0(2, 1000);
    rstn0 = 1'b0;
    tick();
    rstn0 = 1'b1;
    chk("abort_csn",  {31'd0, g_dut[0].csn},  32'd1);
    chk("abort_sclk", {31'd0, g_dut[0].sclk}, 32'd0);
    chk("abort_busy", {31'd0, g_dut[0].busy}, 32'd0);
    chk("abort_req",  {31'd0, g_dut[0].req},  32'd0);
    chk("abort_addr", {15'd0, g_dut[0].addr}, 32'd0);
    for (int i = 0; i < 10; i++) tick();
    chk("abort_no_done", g_dut[0].done_cnt, 32'd0);

    // Frame 4: full frame after the abort
    mon_clr = 1'b1; start0 = 1'b1;
    tick();
    mon_clr = 1'b0; start0 = 1'b0;
    wait_done(0, 2000);
    for (int i = 0; i < 5; i++) tick();
    chk_frame0("f4");
    chk("f4_busy_cycles", g_dut[0].busy_cyc, 32'd304);

    // CLK_DIV=1 instance
    mon_clr = 1'b1; start1 = 1'b1;
    tick();
    mon_clr = 1'b0; start1 = 1'b0;
    chk("d1_busy_next", {31'd0, g_dut[1].busy}, 32'd1);
    wait_done(1, 1000);
    for (int i = 0; i < 5; i++) tick();
    chk("d1_ncmd", g_dut[1].cmd_q.size(), 32'd1);
    chk("d1_cmd", {24'd0, g_dut[1].cmd_q[0]}, 32'h2C);
    chk("d1_nwords", g_dut[1].word_q.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("d1_word", {16'd0, g_dut[1].word_q[i]}, 32'hA5C3 + 32'(i));
    chk("d1_ndone", g_dut[1].done_cnt, 32'd1);
    chk("d1_busy_cycles", g_dut[1].busy_cyc, 32'd156);
    chk("d1_sclk_toggle", g_dut[1].sclk_hold_err, 32'd0);
    chk("d1_mosi_stable", g_dut[1].mosi_unstable, 32'd0);
    chk("d1_fetch_sclk", g_dut[1].fetch_sclk_err, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
